// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer family.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter with load-clear, enable and a terminal flag at WIDTH-1.
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, per-word bit order and stall.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy,
  output piso_state_t      state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);

  // Load handshake: a word is taken on any rising edge where load_valid && load_ready;
  // load_ready is combinational and the producer must hold p_in until it is taken.

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q;
  logic             mode_q;
  logic             s_out_q;
  logic [CNT_W-1:0] count;
  logic             terminal;
  logic             accept;
  logic             advance;
  logic             drain;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .clear_n  (clear_n),
    .clr      (accept || drain),
    .en       (advance),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    advance    = 1'b0;
    drain      = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_en) begin
          if (terminal) begin
            // Final bit leaving: either chain the next word or fall idle.
            load_ready = 1'b1;
            if (!load_valid) begin
              drain   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = load_valid && load_ready;

  // s_out has its own flop, preloaded with the first bit so it appears the cycle after accept.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sreg_q  <= '0;
      mode_q  <= MSB_FIRST;
      s_out_q <= 1'b0;
    end else if (accept) begin
      sreg_q  <= p_in;
      mode_q  <= lsb_first;
      s_out_q <= (lsb_first == LSB_FIRST) ? p_in[0] : p_in[WIDTH-1];
    end else if (advance) begin
      if (mode_q == LSB_FIRST) begin
        sreg_q  <= sreg_q >> 1;
        s_out_q <= sreg_q[1];
      end else begin
        sreg_q  <= sreg_q << 1;
        s_out_q <= sreg_q[WIDTH-2];
      end
    end else if (drain) begin
      sreg_q  <= '0;
      s_out_q <= 1'b0;
    end
  end

  assign s_out     = s_out_q;
  assign s_valid   = (state_q == SHIFT);
  assign s_last    = s_valid && terminal;
  assign busy      = s_valid;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at WIDTH=4 and WIDTH=8 with a bit-level scoreboard.
module tb_piso_serializer;
  import piso_pkg::*;

  logic clk;
  logic clear_n;

  logic [3:0]  p_in4;
  logic        load_valid4, load_ready4, lsb4, shift_en4;
  logic        s_out4, s_valid4, s_last4, busy4;
  piso_state_t state4;

  logic [7:0]  p_in8;
  logic        load_valid8, load_ready8, lsb8, shift_en8;
  logic        s_out8, s_valid8, s_last8, busy8;
  piso_state_t state8;

  // Each entry is {expected s_out, expected s_last}.
  logic [1:0] exp4_q[$];
  logic [1:0] exp8_q[$];
  logic [1:0] last8;

  int n_checks;
  int n_fail;
  int busy4_cnt;
  int busy8_cnt;

  piso_serializer #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .clear_n    (clear_n),
    .p_in       (p_in4),
    .load_valid (load_valid4),
    .load_ready (load_ready4),
    .lsb_first  (lsb4),
    .shift_en   (shift_en4),
    .s_out      (s_out4),
    .s_valid    (s_valid4),
    .s_last     (s_last4),
    .busy       (busy4),
    .state_dbg  (state4)
  );

  piso_serializer #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .clear_n    (clear_n),
    .p_in       (p_in8),
    .load_valid (load_valid8),
    .load_ready (load_ready8),
    .lsb_first  (lsb8),
    .shift_en   (shift_en8),
    .s_out      (s_out8),
    .s_valid    (s_valid8),
    .s_last     (s_last8),
    .busy       (busy8),
    .state_dbg  (state8)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word4(input logic [3:0] word, input logic lsb);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = lsb ? i : 3 - i;
      exp4_q.push_back({word[idx], (i == 3) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic push_word8(input logic [7:0] word, input logic lsb);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      exp8_q.push_back({word[idx], (i == 7) ? 1'b1 : 1'b0});
    end
  endtask

  // Advance one clock, then score both serial outputs.
  task automatic tick();
    logic en8, v8;
    logic [1:0] e;
    en8 = shift_en8;
    v8  = s_valid8;
    @(posedge clk);
    #1;
    if (s_valid4) begin
      busy4_cnt++;
      if (exp4_q.size() == 0) begin
        check("unexpected_bit4", s_valid4, 1'b0);
      end else begin
        e = exp4_q.pop_front();
        check("s_out4", s_out4, e[1]);
        check("s_last4", s_last4, e[0]);
      end
    end else begin
      check("idle_out4", {s_out4, s_last4, busy4}, 3'b000);
    end
    if (s_valid8) begin
      busy8_cnt++;
      if (v8 && !en8) begin
        check("hold_s_out8", s_out8, last8[1]);
        check("hold_s_last8", s_last8, last8[0]);
      end else if (exp8_q.size() == 0) begin
        check("unexpected_bit8", s_valid8, 1'b0);
      end else begin
        last8 = exp8_q.pop_front();
        check("s_out8", s_out8, last8[1]);
        check("s_last8", s_last8, last8[0]);
      end
    end else begin
      check("idle_out8", {s_out8, s_last8, busy8}, 3'b000);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; busy4_cnt = 0; busy8_cnt = 0; last8 = 2'b00;
    clear_n = 1'b0;
    p_in4 = '0; load_valid4 = 1'b0; lsb4 = 1'b0; shift_en4 = 1'b1;
    p_in8 = '0; load_valid8 = 1'b0; lsb8 = 1'b0; shift_en8 = 1'b1;

    // Reset state
    #2;
    check("rst_out4", {s_out4, s_valid4, s_last4, busy4}, 4'b0000);
    check("rst_out8", {s_out8, s_valid8, s_last8, busy8}, 4'b0000);
    tick();
    tick();
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    check("rst_ready4", load_ready4, 1'b1);
    check("rst_ready8", load_ready8, 1'b1);
    check("rst_state4", state4, IDLE);

    // 1011 MSB-first
    p_in4 = 4'b1011; lsb4 = MSB_FIRST; load_valid4 = 1'b1;
    push_word4(4'b1011, 1'b0);
    busy4_cnt = 0;
    tick();
    load_valid4 = 1'b0;
    check("t1_busy", busy4, 1'b1);
    repeat (3) tick();
    tick();
    check("t1_busy_fall", busy4, 1'b0);
    check("t1_cycles", busy4_cnt, 4);
    check("t1_drained", exp4_q.size(), 0);

    // 1011 LSB-first, order and data toggled mid-word
    p_in4 = 4'b1011; lsb4 = LSB_FIRST; load_valid4 = 1'b1;
    push_word4(4'b1011, 1'b1);
    tick();
    load_valid4 = 1'b0; lsb4 = MSB_FIRST; p_in4 = 4'b0100;
    tick();
    lsb4 = LSB_FIRST;
    tick();
    lsb4 = MSB_FIRST;
    tick();
    tick();
    check("t2_drained", exp4_q.size(), 0);

    // A5 MSB-first on WIDTH=8 with a two-cycle stall after bit 3
    p_in8 = 8'hA5; lsb8 = MSB_FIRST; load_valid8 = 1'b1; shift_en8 = 1'b1;
    push_word8(8'hA5, 1'b0);
    busy8_cnt = 0;
    tick();
    load_valid8 = 1'b0;
    repeat (3) tick();
    shift_en8 = 1'b0;
    repeat (2) tick();
    shift_en8 = 1'b1;
    repeat (4) tick();
    check("t3_last_seen", exp8_q.size(), 0);
    tick();
    check("t3_busy_cycles", busy8_cnt, 10);
    check("t3_idle", busy8, 1'b0);

    // Back-to-back C then 3 with load_valid held
    p_in4 = 4'hC; lsb4 = MSB_FIRST; load_valid4 = 1'b1;
    push_word4(4'hC, 1'b0);
    busy4_cnt = 0;
    tick();
    p_in4 = 4'h3;
    push_word4(4'h3, 1'b0);
    #1;
    check("t4_ready_mid", load_ready4, 1'b0);
    repeat (3) tick();
    #1;
    check("t4_ready_last", load_ready4, 1'b1);
    tick();
    load_valid4 = 1'b0;
    check("t4_gapless", s_valid4, 1'b1);
    repeat (3) tick();
    check("t4_cycles", busy4_cnt, 8);
    tick();
    check("t4_idle", busy4, 1'b0);

    // Load pulsed mid-word is dropped
    p_in4 = 4'h0; lsb4 = MSB_FIRST; load_valid4 = 1'b1;
    push_word4(4'h0, 1'b0);
    busy4_cnt = 0;
    tick();
    load_valid4 = 1'b0;
    tick();
    p_in4 = 4'hF; load_valid4 = 1'b1;
    #1;
    check("t5_ready", load_ready4, 1'b0);
    tick();
    load_valid4 = 1'b0;
    repeat (2) tick();
    tick();
    check("t5_cycles", busy4_cnt, 4);
    check("t5_idle", busy4, 1'b0);

    // Asynchronous clear during bit 2 of 1011
    p_in4 = 4'b1011; lsb4 = MSB_FIRST; load_valid4 = 1'b1;
    push_word4(4'b1011, 1'b0);
    tick();
    load_valid4 = 1'b0;
    repeat (2) tick();
    #3;
    clear_n = 1'b0;
    #1;
    check("t6_abort", {s_out4, s_valid4, s_last4, busy4}, 4'b0000);
    exp4_q.delete();
    #2;
    clear_n = 1'b1;
    #1;
    check("t6_ready", load_ready4, 1'b1);
    repeat (3) tick();
    check("t6_state", state4, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
